// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//
// Control stage ahead of the 16:1 result-select mux bank. Accepts one ALU operation over a
// valid/ready handshake and registers the operands. It drives the 4-bit mux select stable for
// the whole execution window. It waits MC_CYCLES for opcodes 12..15 (one cycle otherwise),
// captures the mux bank output, and offers it downstream over a second valid/ready handshake.
//
// Optional feature: define ALU_FLAGS_EN to add registered zero/negative flags captured together
// with the result.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   op_valid / op_ready   operation handshake (op_ready high only in idle)
//   opcode, a_in, b_in    operation code (becomes mux select) and operands
//   sel, a_q, b_q         registered select and operands, held through exec and done
//   res_in                mux bank output, sampled only on the capture edge
//   res_out, res_valid    registered result and its valid
//   res_ready             downstream accepts res_out
//   flag_zero, flag_neg   (ALU_FLAGS_EN only) result flags, registered with res_out

module alu_op_sequencer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MC_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [3:0]       sel,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  input  logic [WIDTH-1:0] res_in,
  output logic [WIDTH-1:0] res_out,
  output logic             res_valid,
`ifdef ALU_FLAGS_EN
  output logic             flag_zero,
  output logic             flag_neg,
`endif
  input  logic             res_ready
);

  localparam int unsigned CntW = $clog2(MC_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        sel_q, sel_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              res_valid_q, res_valid_d;
`ifdef ALU_FLAGS_EN
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    op_ready    = 1'b0;
`ifdef ALU_FLAGS_EN
    zero_d      = zero_q;
    neg_d       = neg_q;
`endif
    unique case (state_q)
      StIdle: begin
        op_ready = 1'b1;
        if (op_valid) begin
          sel_d   = opcode;
          opa_d   = a_in;
          opb_d   = b_in;
          // Opcodes 12..15 are the multi-cycle group.
          cnt_d   = (opcode[3:2] == 2'b11) ? CntW'(MC_CYCLES - 1) : '0;
          state_d = StExec;
        end
      end
      StExec: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          res_d       = res_in;
          res_valid_d = 1'b1;
          state_d     = StDone;
`ifdef ALU_FLAGS_EN
          zero_d      = (res_in == '0);
          neg_d       = res_in[WIDTH-1];
`endif
        end
      end
      StDone: begin
        // res_valid is always high here, so res_ready alone completes the transfer.
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sel_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
`ifdef ALU_FLAGS_EN
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
`ifdef ALU_FLAGS_EN
      zero_q      <= zero_d;
      neg_q       <= neg_d;
`endif
    end
  end

  assign sel       = sel_q;
  assign a_q       = opa_q;
  assign b_q       = opb_q;
  assign res_out   = res_q;
  assign res_valid = res_valid_q;
`ifdef ALU_FLAGS_EN
  assign flag_zero = zero_q;
  assign flag_neg  = neg_q;
`endif

endmodule
